// File: rtl/instr_fetch_decode_ctrl_if.sv
// Instruction-memory handshake plus the decoded register-file / ALU / memory
// controls produced by the fetch/decode sequencer.
interface instr_fetch_decode_ctrl_if #(
  parameter int PC_WIDTH = 8
);
  logic [7:0]          imem_data;
  logic                imem_valid;
  logic                imem_req;
  logic [PC_WIDTH-1:0] pc;
  logic [1:0]          reg_source;
  logic [1:0]          reg_two;
  logic [1:0]          reg_dest;
  logic                regdst;
  logic                regwrite;
  logic                alu_src;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                instr_done;
  logic [1:0]          state;

  // Sequencer side.
  modport master (
    input  imem_data, imem_valid,
    output imem_req, pc, reg_source, reg_two, reg_dest, regdst, regwrite,
           alu_src, mem_read, mem_write, mem_to_reg, instr_done, state
  );

  // Memory / datapath side.
  modport slave (
    output imem_data, imem_valid,
    input  imem_req, pc, reg_source, reg_two, reg_dest, regdst, regwrite,
           alu_src, mem_read, mem_write, mem_to_reg, instr_done, state
  );
endinterface

// File: rtl/instr_fetch_decode_ctrl.sv
// Multi-cycle FETCH->DECODE->EXEC->WB sequencer for the 8-bit, 4-register CPU.
// Owns the PC and IR; every output is decoded from the state/IR/PC flops only.
module instr_fetch_decode_ctrl #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic                      clk,
  input logic                      rst,
  instr_fetch_decode_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10,
    WB     = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_JMP = 2'b11
  } opcode_e;

  state_e              state_q, state_d;
  logic [7:0]          ir_q, ir_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] jmp_off;
  opcode_e             opcode;
  logic                in_instr;

  assign opcode   = opcode_e'(ir_q[7:6]);
  assign jmp_off  = PC_WIDTH'($signed(ir_q[5:0]));
  assign in_instr = (state_q != FETCH);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    unique case (state_q)
      FETCH: begin
        if (bus.imem_valid) begin
          ir_d    = bus.imem_data;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC:   state_d = WB;
      WB: begin
        // PC only moves on WB->FETCH so it is stable for the whole instruction.
        state_d = FETCH;
        pc_d    = pc_q + PC_WIDTH'(1) + ((opcode == OP_JMP) ? jmp_off : '0);
      end
      default: state_d = FETCH;
    endcase
  end

  // NOTE: clocked state uses non-blocking (<=) so all flops update together
  // from pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= '0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  end

  // Register fields hold the last loaded IR, including during the next FETCH.
  assign bus.reg_source = ir_q[5:4];
  assign bus.reg_two    = ir_q[3:2];
  assign bus.reg_dest   = ir_q[1:0];

  assign bus.imem_req   = (state_q == FETCH);
  assign bus.pc         = pc_q;
  assign bus.state      = state_q;

  // Levels are live DECODE..WB; strobes are single-cycle within that window.
  assign bus.regdst     = in_instr && (opcode == OP_ADD);
  assign bus.alu_src    = in_instr && ((opcode == OP_LW) || (opcode == OP_SW));
  assign bus.mem_to_reg = in_instr && (opcode == OP_LW);
  assign bus.mem_read   = (state_q == EXEC) && (opcode == OP_LW);
  assign bus.mem_write  = (state_q == EXEC) && (opcode == OP_SW);
  assign bus.regwrite   = (state_q == WB) && ((opcode == OP_ADD) || (opcode == OP_LW));
  assign bus.instr_done = (state_q == WB);

endmodule

// File: tb/tb_instr_fetch_decode_ctrl.sv
// Self-checking bench: directed vector table, reset-abort sequence and random
// instruction streams checked against an instruction-level reference model.
module tb_instr_fetch_decode_ctrl;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_decode_ctrl_if #(.PC_WIDTH(PW)) bus ();

  instr_fetch_decode_ctrl #(.PC_WIDTH(PW), .RESET_PC('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural PC and last-loaded instruction.
  int         m_pc;
  logic [7:0] m_ir;

  typedef struct {
    logic [7:0] instr;
    int         stalls;
    bit         noise;
    logic [7:0] exp_pc;    // PC in the FETCH after the instruction
    logic [2:0] exp_ctrl;  // {regdst, alu_src, mem_to_reg} in DECODE
    logic [3:0] exp_rw;    // per phase: bit0 fetch(any), 1 decode, 2 exec, 3 wb
    logic [3:0] exp_mr;
    logic [3:0] exp_mw;
    logic [3:0] exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_next_pc(input int pc, input logic [7:0] ir);
    int off;
    off = 0;
    if (ir[7:6] == 2'b11) begin
      off = int'(ir[5:0]);
      if (off >= 32) off -= 64;
    end
    return (pc + 1 + off + 4 * (2 ** PW)) % (2 ** PW);
  endfunction

  // phase: 0 FETCH, 1 DECODE, 2 EXEC, 3 WB -- expected outputs from the ISA table.
  task automatic check_outputs(input string tag, input int phase);
    bit is_add, is_lw, is_sw, live;
    live   = (phase != 0);
    is_add = live && (m_ir[7:6] == 2'b00);
    is_lw  = live && (m_ir[7:6] == 2'b01);
    is_sw  = live && (m_ir[7:6] == 2'b10);
    check({tag, ".state"},      bus.state,      phase);
    check({tag, ".imem_req"},   bus.imem_req,   phase == 0);
    check({tag, ".pc"},         bus.pc,         m_pc);
    check({tag, ".reg_source"}, bus.reg_source, m_ir[5:4]);
    check({tag, ".reg_two"},    bus.reg_two,    m_ir[3:2]);
    check({tag, ".reg_dest"},   bus.reg_dest,   m_ir[1:0]);
    check({tag, ".regdst"},     bus.regdst,     is_add);
    check({tag, ".alu_src"},    bus.alu_src,    is_lw || is_sw);
    check({tag, ".mem_to_reg"}, bus.mem_to_reg, is_lw);
    check({tag, ".mem_read"},   bus.mem_read,   is_lw && phase == 2);
    check({tag, ".mem_write"},  bus.mem_write,  is_sw && phase == 2);
    check({tag, ".regwrite"},   bus.regwrite,   (is_add || is_lw) && phase == 3);
    check({tag, ".instr_done"}, bus.instr_done, phase == 3);
  endtask

  // Runs one instruction starting from FETCH; returns observed strobe masks.
  task automatic run_instr(input logic [7:0] instr, input int stalls, input bit noise,
                           output logic [2:0] ctrl, output logic [3:0] rw,
                           output logic [3:0] mr, output logic [3:0] mw,
                           output logic [3:0] done);
    rw = '0; mr = '0; mw = '0; done = '0;
    for (int i = 0; i < stalls; i++) begin
      bus.imem_valid = 1'b0;
      bus.imem_data  = 8'($urandom);
      tick();
      check_outputs("stall", 0);
      rw[0] |= bus.regwrite; mr[0] |= bus.mem_read;
      mw[0] |= bus.mem_write; done[0] |= bus.instr_done;
    end
    bus.imem_valid = 1'b1;
    bus.imem_data  = instr;
    for (int ph = 1; ph <= 3; ph++) begin
      tick();
      if (ph == 1) begin
        m_ir = instr;
        ctrl = {bus.regdst, bus.alu_src, bus.mem_to_reg};
      end
      check_outputs($sformatf("ph%0d", ph), ph);
      rw[ph] = bus.regwrite; mr[ph] = bus.mem_read;
      mw[ph] = bus.mem_write; done[ph] = bus.instr_done;
      bus.imem_valid = noise ? 1'($urandom) : 1'b0;
      bus.imem_data  = 8'($urandom);
    end
    bus.imem_valid = 1'b0;
    tick();
    m_pc = model_next_pc(m_pc, instr);
    check_outputs("next_fetch", 0);
  endtask

  initial begin
    logic [2:0] ctrl;
    logic [3:0] rw, mr, mw, done;

    vecs[0] = '{8'h1B, 0, 1'b0, 8'h01, 3'b100, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
    vecs[1] = '{8'h46, 0, 1'b0, 8'h02, 3'b011, 4'b1000, 4'b0100, 4'b0000, 4'b1000};
    vecs[2] = '{8'hB1, 3, 1'b1, 8'h03, 3'b010, 4'b0000, 4'b0000, 4'b0100, 4'b1000};
    vecs[3] = '{8'h00, 0, 1'b1, 8'h04, 3'b100, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
    vecs[4] = '{8'h7F, 1, 1'b0, 8'h05, 3'b011, 4'b1000, 4'b0100, 4'b0000, 4'b1000};
    vecs[5] = '{8'hFE, 0, 1'b1, 8'h04, 3'b000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    vecs[6] = '{8'hC3, 2, 1'b0, 8'h08, 3'b000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    vecs[7] = '{8'hE0, 0, 1'b1, 8'hE9, 3'b000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};

    rst            = 1'b1;
    bus.imem_valid = 1'b1;
    bus.imem_data  = 8'hFF;
    m_pc = 0;
    m_ir = 8'h00;
    tick();
    tick();
    check_outputs("reset", 0);
    rst = 1'b0;
    bus.imem_valid = 1'b0;

    foreach (vecs[i]) begin
      run_instr(vecs[i].instr, vecs[i].stalls, vecs[i].noise, ctrl, rw, mr, mw, done);
      check($sformatf("vec%0d.pc", i),       bus.pc, vecs[i].exp_pc);
      check($sformatf("vec%0d.ctrl", i),     ctrl,   vecs[i].exp_ctrl);
      check($sformatf("vec%0d.regwrite", i), rw,     vecs[i].exp_rw);
      check($sformatf("vec%0d.mem_read", i), mr,     vecs[i].exp_mr);
      check($sformatf("vec%0d.mem_write", i), mw,    vecs[i].exp_mw);
      check($sformatf("vec%0d.done", i),     done,   vecs[i].exp_done);
    end

    // Reset asserted mid-EXEC of SW 8'h84 aborts it immediately.
    bus.imem_valid = 1'b1;
    bus.imem_data  = 8'h84;
    tick();
    bus.imem_valid = 1'b0;
    tick();
    check("abort.mem_write_before", bus.mem_write, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("abort.mem_write",  bus.mem_write, 1'b0);
    check("abort.state",      bus.state,     2'b00);
    check("abort.pc",         bus.pc,        8'h00);
    check("abort.imem_req",   bus.imem_req,  1'b1);
    tick();
    rst  = 1'b0;
    m_pc = 0;
    m_ir = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_outputs("after_abort", 0);
    end

    // JMP -2 from PC 0 wraps to the top of the address space.
    run_instr(8'hFE, 0, 1'b0, ctrl, rw, mr, mw, done);
    check("jmp_wrap.pc", bus.pc, 8'hFF);

    for (int n = 0; n < 300; n++)
      run_instr(8'($urandom), int'($urandom_range(0, 2)), 1'b1, ctrl, rw, mr, mw, done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
